// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-K counter family (up and down variants).
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of bits needed to represent value; never less than 1.
  function automatic int clogb2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/down_counter_core.sv
// N-bit modulo-K down-count register: saturating load, forced reload to K-1,
// decrement with optional wrap at zero.
module down_counter_core
  import counter_pkg::*;
#(
  parameter int K      = 20,
  parameter int RELOAD = 0,
  localparam int N     = clogb2(K - 1)
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         load_i,
  input  logic [N-1:0] load_value_i,
  input  logic         set_max_i,
  input  logic         dec_i,
  output logic [N-1:0] q_o,
  output logic         zero_o
);

  localparam int unsigned KMAX  = K - 1;
  localparam logic [N-1:0] QMAX = N'(K - 1);
  localparam logic [N-1:0] ONE  = N'(1);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  int unsigned  lv_full;

  // Next count: load (saturated) beats forced reload beats decrement.
  always_comb begin
    q_d     = q_q;
    lv_full = 32'(load_value_i);
    if (load_i) begin
      if (lv_full > KMAX) q_d = QMAX;
      else                q_d = load_value_i;
    end else if (set_max_i) begin
      q_d = QMAX;
    end else if (dec_i) begin
      if (q_q == '0) begin
        if (RELOAD != 0) q_d = QMAX;
        else             q_d = q_q;
      end else begin
        q_d = q_q - ONE;
      end
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q_o    = q_q;
  assign zero_o = (q_q == '0);

endmodule

// File: rtl/countdown_modulo_k.sv
// Loadable modulo-K down counter with IDLE/RUN/PAUSE/DONE control.
// One-shot (RELOAD=0) stops at zero; reload mode (RELOAD=1) wraps to K-1.
module countdown_modulo_k
  import counter_pkg::*;
#(
  parameter int K      = 20,
  parameter int RELOAD = 0,
  localparam int N     = clogb2(K - 1)
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  output logic [N-1:0] Q,
  output logic         borrow,
  output logic         done,
  output logic         busy
);

  state_t state_q;
  logic   done_q;
  logic   zero;
  logic   in_run;
  logic   start_only;
  logic   core_dec;
  logic   core_set_max;

  assign in_run     = (state_q == ST_RUN);
  assign start_only = start && !stop;

  // stop (and load) suppress counting on the same edge.
  assign core_dec     = !load && in_run && !stop && enable;
  assign core_set_max = !load && (state_q == ST_DONE) && start_only;

  down_counter_core #(
    .K      (K),
    .RELOAD (RELOAD)
  ) u_core (
    .clk          (clk),
    .aclr         (aclr),
    .load_i       (load),
    .load_value_i (load_value),
    .set_max_i    (core_set_max),
    .dec_i        (core_dec),
    .q_o          (Q),
    .zero_o       (zero)
  );

  // Control FSM and registered done pulse; load overrides everything but aclr.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else if (load) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_only) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_PAUSE;
          end else if (enable && zero) begin
            done_q <= 1'b1;
            if (RELOAD == 0) state_q <= ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (start_only) state_q <= ST_RUN;
        end
        ST_DONE: begin
          if (start_only) state_q <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign borrow = in_run && enable && zero;
  assign busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done   = done_q;

endmodule

// File: tb/tb_countdown_modulo_k.sv
// Directed bench: three instances (K=20 one-shot, K=20 reload, K=2 reload)
// share one stimulus set; each section checks the instance it targets.
module tb_countdown_modulo_k;

  logic       clk = 1'b0;
  logic       aclr, enable, load, start, stop;
  logic [4:0] lv;

  logic [4:0] q_a, q_b;
  logic [0:0] q_c;
  logic       borrow_a, done_a, busy_a;
  logic       borrow_b, done_b, busy_b;
  logic       borrow_c, done_c, busy_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  countdown_modulo_k #(.K(20), .RELOAD(0)) dut_a (
    .clk(clk), .aclr(aclr), .enable(enable), .load(load), .load_value(lv),
    .start(start), .stop(stop), .Q(q_a), .borrow(borrow_a), .done(done_a), .busy(busy_a)
  );

  countdown_modulo_k #(.K(20), .RELOAD(1)) dut_b (
    .clk(clk), .aclr(aclr), .enable(enable), .load(load), .load_value(lv),
    .start(start), .stop(stop), .Q(q_b), .borrow(borrow_b), .done(done_b), .busy(busy_b)
  );

  countdown_modulo_k #(.K(2), .RELOAD(1)) dut_c (
    .clk(clk), .aclr(aclr), .enable(enable), .load(load), .load_value(lv[0:0]),
    .start(start), .stop(stop), .Q(q_c), .borrow(borrow_c), .done(done_c), .busy(busy_c)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    lv   = 5'(v);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    aclr = 1'b1; enable = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; lv = '0;
    #2;
    chk("rst_q",      int'(q_a), 0);
    chk("rst_busy",   int'(busy_a), 0);
    chk("rst_done",   int'(done_a), 0);
    chk("rst_borrow", int'(borrow_a), 0);
    #1 aclr = 1'b0;
    cyc();

    // One-shot countdown from 5
    do_load(5);
    chk("os_load_q",    int'(q_a), 5);
    chk("os_load_busy", int'(busy_a), 0);
    do_start();
    chk("os_start_q",    int'(q_a), 5);
    chk("os_start_busy", int'(busy_a), 1);
    enable = 1'b1;
    #1;
    chk("os_borrow5", int'(borrow_a), 0);
    for (int v = 4; v >= 0; v--) begin
      cyc();
      chk("os_cnt_q",      int'(q_a), v);
      chk("os_cnt_done",   int'(done_a), 0);
      chk("os_cnt_borrow", int'(borrow_a), (v == 0) ? 1 : 0);
    end
    cyc();
    chk("os_exp_done",   int'(done_a), 1);
    chk("os_exp_q",      int'(q_a), 0);
    chk("os_exp_busy",   int'(busy_a), 0);
    chk("os_exp_borrow", int'(borrow_a), 0);
    cyc();
    chk("os_post_done", int'(done_a), 0);
    chk("os_post_q",    int'(q_a), 0);

    // Reload mode from 2
    enable = 1'b0;
    do_load(2);
    do_start();
    chk("rl_q2", int'(q_b), 2);
    enable = 1'b1;
    cyc();
    chk("rl_q1", int'(q_b), 1);
    cyc();
    chk("rl_q0",      int'(q_b), 0);
    chk("rl_borrow",  int'(borrow_b), 1);
    chk("rl_done0",   int'(done_b), 0);
    cyc();
    chk("rl_wrap_q",    int'(q_b), 19);
    chk("rl_wrap_done", int'(done_b), 1);
    chk("rl_wrap_busy", int'(busy_b), 1);
    cyc();
    chk("rl_q18",    int'(q_b), 18);
    chk("rl_done18", int'(done_b), 0);
    chk("rl_busy18", int'(busy_b), 1);

    // Saturation and zero-start expiry
    enable = 1'b0;
    do_load(31);
    chk("sat_q", int'(q_a), 19);
    do_load(0);
    chk("zero_q", int'(q_a), 0);
    do_start();
    enable = 1'b1;
    #1;
    chk("zero_borrow", int'(borrow_a), 1);
    cyc();
    chk("zero_done", int'(done_a), 1);
    chk("zero_busy", int'(busy_a), 0);
    chk("zero_q2",   int'(q_a), 0);

    // Pause, start+stop, resume, enable gating
    enable = 1'b0;
    do_load(10);
    do_start();
    enable = 1'b1;
    cyc(); cyc(); cyc();
    chk("pz_q7", int'(q_a), 7);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("pz_stop_q",    int'(q_a), 7);
    chk("pz_stop_busy", int'(busy_a), 1);
    cyc(); cyc();
    chk("pz_hold_q", int'(q_a), 7);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("pz_ss_q", int'(q_a), 7);
    cyc();
    chk("pz_ss_hold_q", int'(q_a), 7);
    do_start();
    chk("pz_resume_q", int'(q_a), 7);
    cyc();
    chk("pz_resume_q6", int'(q_a), 6);
    for (int i = 0; i < 4; i++) begin
      enable = (i % 2 == 1);
      cyc();
      chk("gate_q", int'(q_a), 6 - (i + 1) / 2);
    end

    // Asynchronous clear mid-run, then load beating start in DONE
    enable = 1'b0;
    do_load(14);
    do_start();
    enable = 1'b1;
    cyc(); cyc();
    chk("ac_q12", int'(q_a), 12);
    #2 aclr = 1'b1;
    #1;
    chk("ac_q",      int'(q_a), 0);
    chk("ac_busy",   int'(busy_a), 0);
    chk("ac_done",   int'(done_a), 0);
    chk("ac_borrow", int'(borrow_a), 0);
    #1 aclr = 1'b0;
    cyc();
    chk("ac_idle_q",    int'(q_a), 0);
    chk("ac_idle_busy", int'(busy_a), 0);
    do_start();
    chk("ac_borrow_run", int'(borrow_a), 1);
    cyc();
    chk("ac_exp_done", int'(done_a), 1);
    chk("ac_exp_busy", int'(busy_a), 0);
    lv = 5'd8; load = 1'b1; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    chk("ld_pri_q",    int'(q_a), 8);
    chk("ld_pri_busy", int'(busy_a), 0);
    chk("ld_pri_done", int'(done_a), 0);
    cyc();
    chk("ld_pri_hold_q", int'(q_a), 8);

    // K=2 reload toggling
    enable = 1'b0;
    do_load(0);
    do_start();
    chk("k2_q0", int'(q_c), 0);
    enable = 1'b1;
    #1;
    chk("k2_borrow", int'(borrow_c), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("k2_q",    int'(q_c), i % 2);
      chk("k2_done", int'(done_c), i % 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
